muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle HI/LO unit for the single-cycle MIPS core.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, and owns the architectural HI and LO registers; also performs MTHI and MTLO.
- The core decoder pulses `start` with the decoded operation and holds the PC while `busy` is asserted. MFHI/MFLO read `hi`/`lo` directly.

Parameters:
- WIDTH, 32, operand, HI and LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- clk_enable  in  1  global advance enable; when low, all state is frozen
- start  in  1  request; sampled only in IDLE
- op  in  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
- rs_val  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- rt_val  in  WIDTH  multiplier / divisor
- busy  out  1  operation in flight; core stalls while high
- done  out  1  one-cycle pulse in the cycle after HI/LO are updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- div_by_zero  out  1  last DIV/DIVU had rt_val==0; cleared by the next accepted start

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0. Reset mid-operation aborts it; no partial HI/LO write occurs.
- clk_enable=0: no register changes, including the FSM, the counter and the done pulse.
- States: IDLE, MUL, DIV, FIX.
- Accept: at a clock edge in IDLE with start=1 and clk_enable=1. Operands are captured at accept; later input changes are ignored.
- MTHI/MTLO:
  - The HI or LO write happens at the accept edge.
  - busy never rises; done pulses in the next cycle.
- MULT/MULTU/DIV/DIVU, captured values:
  - Operand magnitudes (abs for signed ops, raw for unsigned ops).
  - Result sign flags: product/quotient sign = sign(rs) xor sign(rt); remainder sign = sign(rs).
  - The FSM moves to MUL or DIV, the counter is loaded with WIDTH, and busy=1 from the cycle after accept.
- MUL: shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle, counter decrements; at counter 1 the FSM goes to FIX.
- DIV: restoring division, one quotient bit per cycle, remainder WIDTH+1 bits; at counter 1 the FSM goes to FIX.
- FIX:
  - Applies two's-complement negation per the sign flags.
  - Writes hi/lo (MUL: hi=upper half, lo=lower half; DIV: lo=quotient, hi=remainder).
  - busy drops at this edge and the FSM returns to IDLE; done=1 for the following cycle.
- Latency: accept edge to HI/LO write = WIDTH+1 edges (33 at default).
- Divide by zero: the FSM skips DIV and goes from accept straight to FIX. Result hi=rs_val, lo={WIDTH{1}}, div_by_zero=1, latency 1 edge.
- Signed DIV of 0x80000000 by -1: lo=0x80000000, hi=0 (magnitude wrap; no trap).
- start while busy: ignored and not queued.
- start in the same cycle as done: accepted, because the FSM is already IDLE.
- MUL arithmetic is exact mod 2^(2*WIDTH). Negating 0 yields 0.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in MUL, when the unshifted remaining multiplier magnitude is 0, the FSM goes to FIX on the next edge. Latency = (index of the highest set multiplier bit + 1) + 1 edges. A multiplier of 0 takes 1 edge (accept goes straight to FIX).
- Undefined: fixed WIDTH+1 latency for all multiplies. DIV is unaffected either way.

Decomposition:
- muldiv_pkg holds:
  - typedef muldiv_op_t (3-bit enum, encodings MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5)
  - typedef muldiv_state_t
  - localparam MULDIV_WIDTH=32
- One combinational sub-module, muldiv_step:
  - Inputs: accumulator/remainder, operand, mode.
  - Outputs: next accumulator/remainder and quotient bit.
  - Instantiated once.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle.
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. With MULDIV_EARLY_OUT_EN, latency=4 edges.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=7 -> lo=14, hi=2.
- DIVU rs=0x55, rt=0 -> div_by_zero=1, hi=0x55, lo=0xFFFFFFFF, done 1 cycle after accept. The next MTLO clears div_by_zero.
- MULT started; MTHI 0x1234 pulsed during busy -> ignored, HI ends as the product.
- reset asserted at cycle 10 of a MULT -> busy=0, hi=lo=0. Then MTHI 0x1234 -> hi=0x1234 next edge, busy stays 0.
- clk_enable held low for 5 cycles mid-DIV -> result unchanged, latency extended by exactly 5 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the HI/LO multiply/divide sequencer:
//   MULDIV_WIDTH    default operand / HI / LO width
//   muldiv_op_t     operation encoding driven by the core decoder
//   muldiv_state_t  sequencer FSM states
//   step_mode_t     selects the multiply or divide datapath in muldiv_step
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_t;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_t;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One iteration of the multiply/divide datapath (purely combinational).
//   mode_i   STEP_MUL: acc_o = acc_i + opnd_i (caller pre-gates opnd_i with
//                      the current multiplier bit and pre-shifts it)
//            STEP_DIV: restoring-division step on {remainder, dividend};
//                      opnd_i[WIDTH-1:0] is the divisor
//   acc_i    accumulator (MUL) or {remainder, dividend/quotient} (DIV)
//   opnd_i   shifted multiplicand (MUL) or zero-extended divisor (DIV)
//   acc_o    next accumulator; in DIV mode bit 0 is left clear
//   q_bit_o  quotient bit produced by this step (DIV only, 0 in MUL)
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic               mode_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] opnd_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               q_bit_o
);

    // Partial remainder shifted left with the next dividend bit: WIDTH+1 bits.
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        acc_o    = acc_i;
        q_bit_o  = 1'b0;
        shifted  = acc_i[2*WIDTH-1:WIDTH-1];
        fits     = shifted >= {1'b0, opnd_i[WIDTH-1:0]};
        // When the divisor fits, the difference is below the divisor, so the
        // truncation to WIDTH bits never loses a set bit.
        rem_next = fits ? WIDTH'(shifted - {1'b0, opnd_i[WIDTH-1:0]})
                        : shifted[WIDTH-1:0];

        if (mode_i == STEP_DIV) begin
            acc_o   = {rem_next, acc_i[WIDTH-2:0], 1'b0};
            q_bit_o = fits;
        end else begin
            acc_o   = acc_i + opnd_i;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative HI/LO unit for the single-cycle MIPS core: MULT/MULTU/DIV/DIVU one
// bit per cycle, MTHI/MTLO in the accept cycle. Owns the HI and LO registers.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   clk_enable     global advance enable; low freezes every register
//   start, op      request (muldiv_op_t encoding), sampled only in IDLE
//   rs_val, rt_val operands, captured at accept
//   busy           operation in flight (core stalls)
//   done           one-cycle pulse in the cycle after HI/LO are written
//   hi, lo         architectural HI / LO
//   div_by_zero    last DIV/DIVU had rt_val == 0; cleared by next accept
//
// Build option: define MULDIV_EARLY_OUT_EN to finish a multiply as soon as
// the remaining multiplier magnitude is zero.
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    localparam int CNT_W = $clog2(WIDTH + 1);

    muldiv_state_t      state_q;
    step_mode_t         mode_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] opnd_q;     // multiplicand (shifts left) or divisor
    logic [WIDTH-1:0]   mplier_q;   // remaining multiplier (shifts right)
    logic               neg_q_q;    // negate product / quotient
    logic               neg_r_q;    // negate remainder
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q, dz_q;

    // Operand capture.
    muldiv_op_t       op_e;
    logic             op_signed, rs_neg, rt_neg;
    logic [WIDTH-1:0] mag_rs, mag_rt;

    assign op_e      = muldiv_op_t'(op);
    assign op_signed = (op_e == MULT) || (op_e == DIV);
    assign rs_neg    = op_signed & rs_val[WIDTH-1];
    assign rt_neg    = op_signed & rt_val[WIDTH-1];
    // -0x80..0 wraps to itself, which is the correct unsigned magnitude.
    assign mag_rs    = rs_neg ? -rs_val : rs_val;
    assign mag_rt    = rt_neg ? -rt_val : rt_val;

    // One datapath step.
    logic [2*WIDTH-1:0] step_opnd, step_acc, acc_d;
    logic               step_q;

    assign step_opnd = (mode_q == STEP_MUL && !mplier_q[0]) ? '0 : opnd_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_i  (mode_q),
        .acc_i   (acc_q),
        .opnd_i  (step_opnd),
        .acc_o   (step_acc),
        .q_bit_o (step_q)
    );

    // The quotient bit lands in the slot the step vacated; it is 0 in MUL.
    assign acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};

    // Last multiply step: counter exhausted or, with early-out, no set
    // multiplier bits remain after the one consumed this cycle.
    logic mul_last;
    assign mul_last = (cnt_q == CNT_W'(1)) ||
                      (EARLY_OUT && (mplier_q[WIDTH-1:1] == '0));

    // Sign fix-up applied in FIX.
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quot_res, rem_res;

    assign prod_res = neg_q_q ? -acc_q : acc_q;
    assign quot_res = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_res  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= STEP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            mplier_q <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else if (clk_enable) begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        unique case (op_e)
                            MTHI: begin
                                hi_q   <= rs_val;
                                done_q <= 1'b1;
                                dz_q   <= 1'b0;
                            end
                            MTLO: begin
                                lo_q   <= rs_val;
                                done_q <= 1'b1;
                                dz_q   <= 1'b0;
                            end
                            MULT, MULTU: begin
                                mode_q   <= STEP_MUL;
                                acc_q    <= '0;
                                opnd_q   <= {{WIDTH{1'b0}}, mag_rs};
                                mplier_q <= mag_rt;
                                neg_q_q  <= rs_neg ^ rt_neg;
                                neg_r_q  <= 1'b0;
                                cnt_q    <= CNT_W'(WIDTH);
                                busy_q   <= 1'b1;
                                dz_q     <= 1'b0;
                                state_q  <= (EARLY_OUT && mag_rt == '0) ? ST_FIX : ST_MUL;
                            end
                            DIV, DIVU: begin
                                mode_q  <= STEP_DIV;
                                opnd_q  <= {{WIDTH{1'b0}}, mag_rt};
                                cnt_q   <= CNT_W'(WIDTH);
                                busy_q  <= 1'b1;
                                if (rt_val == '0) begin
                                    // Preload the final answer; FIX copies it
                                    // out with no sign correction.
                                    acc_q   <= {rs_val, {WIDTH{1'b1}}};
                                    neg_q_q <= 1'b0;
                                    neg_r_q <= 1'b0;
                                    dz_q    <= 1'b1;
                                    state_q <= ST_FIX;
                                end else begin
                                    acc_q   <= {{WIDTH{1'b0}}, mag_rs};
                                    neg_q_q <= rs_neg ^ rt_neg;
                                    neg_r_q <= rs_neg;
                                    dz_q    <= 1'b0;
                                    state_q <= ST_DIV;
                                end
                            end
                            default: ;  // reserved encodings are not accepted
                        endcase
                    end
                end
                ST_MUL: begin
                    acc_q    <= acc_d;
                    opnd_q   <= opnd_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (mul_last) state_q <= ST_FIX;
                end
                ST_DIV: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    if (mode_q == STEP_MUL) begin
                        hi_q <= prod_res[2*WIDTH-1:WIDTH];
                        lo_q <= prod_res[WIDTH-1:0];
                    end else begin
                        hi_q <= rem_res;
                        lo_q <= quot_res;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed bench for muldiv_sequencer. Stimulus pushes the hand-computed
// HI/LO/div_by_zero and completion cycle into a queue; a monitor pops and
// compares on every done pulse. Build with MULDIV_EARLY_OUT_EN to match an
// RTL built with the early-out multiply.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          acc_edge;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: present the request, let the next edge accept it.
    task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        rs_val   = ~a;
        rt_val   = 32'h5A5A_0F0F;
        acc_edge = cyc;
    endtask

    // lat = edges from the accept edge to the HI/LO write edge.
    task automatic push(input string name, input logic [31:0] h, input logic [31:0] l,
                        input logic dz, input int lat);
        exp_t e;
        e.name     = name;
        e.hi       = h;
        e.lo       = l;
        e.dz       = dz;
        e.done_cyc = acc_edge + lat;
        sb.push_back(e);
        model_hi = h;
        model_lo = l;
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", 64'(sb.size()), 64'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check({e.name, "_hi"},      64'(hi),          64'(e.hi));
                check({e.name, "_lo"},      64'(lo),          64'(e.lo));
                check({e.name, "_dz"},      64'(div_by_zero), 64'(e.dz));
                check({e.name, "_latency"}, 64'(cyc),         64'(e.done_cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        reset = 1'b1; clk_enable = 1'b1; start = 1'b0;
        op = 3'd0; rs_val = '0; rt_val = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);
        check("reset_dz",   64'(div_by_zero), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Largest unsigned product; busy must be high for exactly 33 cycles.
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check("multu_busy_cycles", 64'(n), 64'd33);
        wait_drain(10);
        @(negedge clk);
        check("multu_done_width", 64'(done), 64'd0);

        issue(MULT, 32'hFFFF_FFFD, 32'd7);
        push("mult_neg3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, EARLY ? 4 : 33);
        wait_drain(60);

        issue(MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        push("mult_neg2xneg3", 32'h0, 32'h6, 1'b0, EARLY ? 3 : 33);
        wait_drain(60);

        issue(MULT, 32'h0000_1234, 32'h0);
        push("mult_by_zero", 32'h0, 32'h0, 1'b0, EARLY ? 1 : 33);
        wait_drain(60);

        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        push("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        wait_drain(60);

        issue(DIVU, 32'd100, 32'd7);
        push("divu_100_7", 32'd2, 32'd14, 1'b0, 33);
        wait_drain(60);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        push("div_minint_neg1", 32'h0, 32'h8000_0000, 1'b0, 33);
        wait_drain(60);

        // Divide by zero, then an MTLO that clears the flag.
        issue(DIVU, 32'h55, 32'h0);
        push("divu_by_zero", 32'h55, 32'hFFFF_FFFF, 1'b1, 1);
        wait_drain(10);
        issue(MTLO, 32'h0000_ABCD, 32'h0);
        push("mtlo_clears_dz", model_hi, 32'h0000_ABCD, 1'b0, 0);
        wait_drain(10);

        // MTHI pulsed while busy is dropped.
        issue(MULT, 32'h0001_0000, 32'h4000_0000);
        push("mult_ignores_mthi", 32'h0000_4000, 32'h0, 1'b0, EARLY ? 32 : 33);
        repeat (4) @(negedge clk);
        check("busy_during_mult", 64'(busy), 64'd1);
        start = 1'b1; op = MTHI; rs_val = 32'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain(60);

        // A start presented in the done cycle is accepted.
        issue(MULTU, 32'd3, 32'd5);
        push("multu_3x5", 32'h0, 32'd15, 1'b0, EARLY ? 4 : 33);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        check("done_seen_b2b", 64'(done), 64'd1);
        issue(MTLO, 32'h77, 32'h0);
        push("mtlo_in_done_cycle", 32'h0, 32'h77, 1'b0, 0);
        wait_drain(10);

        // Freeze for 5 edges mid-divide: latency grows by exactly 5.
        issue(DIVU, 32'd1000, 32'd3);
        push("divu_stall", 32'd1, 32'd333, 1'b0, 38);
        repeat (10) @(negedge clk);
        clk_enable = 1'b0;
        repeat (5) @(negedge clk);
        clk_enable = 1'b1;
        wait_drain(60);

        // Reset in the middle of a multiply aborts it with no HI/LO write.
        issue(MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_hi = '0;
        model_lo = '0;
        issue(MTHI, 32'h1234, 32'h0);
        push("mthi_after_reset", 32'h1234, 32'h0, 1'b0, 0);
        @(negedge clk);
        check("mthi_no_busy", 64'(busy), 64'd0);
        wait_drain(10);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
